max_min_tracker: RTL and testbench
==================================

# max_min_tracker

Sequential front-end that feeds the existing `max_comparator` stage. It accepts a stream of N signed 8-bit samples over a valid/ready handshake and tags each sample with its 5-bit arrival index to form a 13-bit {value,index} word. It folds each word into running maximum and minimum registers through two `max_comparator` instances. After the N-th sample it presents the overall max and min words with a one-cycle `done` pulse.

## Interface
- `N`, 32, samples per run; legal 2..32 (index is 5 bits).
- `DW`, 8, sample value width (signed).
- `IW`, 5, index width; packed word width is DW+IW = 13.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  begin a run; sampled only in IDLE.
- `in_valid`  in  1  `in_value` is valid this cycle.
- `in_value`  in  DW  signed sample.
- `in_ready`  out  1  block accepts a sample this cycle.
- `busy`  out  1  high in ACCEPT state.
- `done`  out  1  one-cycle pulse; results valid.
- `out_max`  out  DW+IW  signed {value,index} of the largest sample.
- `out_min`  out  DW+IW  signed {value,index} of the smallest sample.

## Operation
- FSM states: IDLE, ACCEPT, DONE.
  - IDLE -> ACCEPT on `start`. `cnt` is cleared to 0.
  - ACCEPT -> DONE on the accept of sample index N-1.
  - DONE -> IDLE unconditionally after 1 cycle.
- `start` is ignored in ACCEPT and DONE. There is no restart mid-run.
- An accept occurs when `in_valid && in_ready`. `in_ready` is 1 only in ACCEPT.
- Tagged word = {in_value, cnt[IW-1:0]}. `cnt` increments on each accept.
- First accept of a run (cnt==0): the tagged word loads both `max_r` and `min_r` directly.
- Later accepts use two comparator instances:
  - Max instance: a=`max_r`, b=word. `max_r` <= `out_value_max`.
  - Min instance: a=word, b=`min_r`. `min_r` <= `out_value_min`.
- Comparisons use only the signed value field [12:5]. The index field never affects ordering.
- Ties keep the running (earlier-index) word in both registers.
- `out_max`/`out_min` are driven from `max_r`/`min_r`. They are updated during ACCEPT and are meaningful from the `done` cycle onward. They hold until the first accept of the next run.
- Reset values: `max_r`, `min_r`, `cnt` = 0. State = IDLE. `in_ready`, `busy`, `done` = 0.
- `rst` asserted mid-run clears everything immediately. The partial run is discarded and no `done` is produced.

## Timing
- `in_ready` and `busy` are decoded from state only. There is no combinational path from `in_valid`.
- One sample can be accepted per cycle.
- `done` rises in the cycle after the N-th accept and lasts exactly 1 cycle.
- Minimum run length: 1 (start) + N (accepts) + 1 (DONE) cycles. Back-to-back runs need `start` in or after the IDLE cycle that follows DONE.
- Gaps in `in_valid` stall the run indefinitely. `cnt`, `max_r` and `min_r` hold during gaps.
- `in_value` presented while `in_ready`=0 is ignored.

## Structure
- Shared package `tracker_pkg`, containing:
  - `DW`, `IW` localparams.
  - `typedef logic signed [DW+IW-1:0] tagged_t`.
  - State enum `trk_state_t` {IDLE, ACCEPT, DONE}.
- Sub-module: two instances of the existing `max_comparator`, one per running register. All sequential logic lives in `max_min_tracker`.

## Test plan
- Ascending run: N=32, samples i-16 for i=0..31 -> `out_max`={8'sd15,5'd31}, `out_min`={-8'sd16,5'd0}, `done` 1 cycle after the last accept.
- Ties: all 32 samples = 7 -> `out_max` = `out_min` = {8'sd7,5'd0}.
- Extremes with stalls:
  - Stimulus: `in_valid` toggled randomly. 127 arrives at index 9, -128 at index 20, other samples 0.
  - Response: `out_max`={127,9}, `out_min`={-128,20}. Accepts occur only when `in_valid`=1. Run completes after exactly 32 accepts.
- Reset mid-run: `rst` pulsed after 10 accepts -> all outputs 0, state IDLE. A following full run gives correct results with indices starting at 0.
- Start ignored: `start` held high throughout a run -> no count reset. Exactly one `done`. A new run begins only after DONE->IDLE.
- Descending run: samples 100-3i -> `out_max`={100,0}, `out_min`={7,31}.

Source files
------------

// File: rtl/tracker_pkg.sv
// Shared types for the max/min tracker: field widths, the tagged {value,index} word and FSM states.
package tracker_pkg;

   localparam int unsigned DW = 8;
   localparam int unsigned IW = 5;

   typedef logic signed [DW+IW-1:0] tagged_t;

   typedef enum logic [1:0] {
      IDLE,
      ACCEPT,
      DONE
   } trk_state_t;

endpackage

// File: rtl/max_comparator.sv
// Combinational {value,index} comparator: orders on the signed value field only.
module max_comparator
   import tracker_pkg::*;
(
   input  tagged_t a_i,
   input  tagged_t b_i,
   output tagged_t out_value_max_o,
   output tagged_t out_value_min_o
);

   logic signed [DW-1:0] a_val;
   logic signed [DW-1:0] b_val;

   assign a_val = a_i[DW+IW-1:IW];
   assign b_val = b_i[DW+IW-1:IW];

   // On a tie the max output keeps a and the min output keeps b, so callers place the
   // running word on the side that must win ties.
   assign out_value_max_o = (b_val > a_val) ? b_i : a_i;
   assign out_value_min_o = (a_val < b_val) ? a_i : b_i;

endmodule

// File: rtl/max_min_tracker.sv
// Accepts N signed samples over valid/ready, tags each with its arrival index and
// tracks the running max and min words, pulsing done once the run completes.
module max_min_tracker
   import tracker_pkg::*;
#(
   parameter int unsigned N = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 in_valid_i,
   input  logic signed [DW-1:0] in_value_i,
   output logic                 in_ready_o,
   output logic                 busy_o,
   output logic                 done_o,
   output tagged_t              out_max_o,
   output tagged_t              out_min_o
);

   trk_state_t    state_q, state_d;
   logic [IW-1:0] cnt_q, cnt_d;
   tagged_t       max_q, max_d;
   tagged_t       min_q, min_d;
   tagged_t       word;
   tagged_t       cmp_max;
   tagged_t       cmp_min;
   logic          accept;

   assign word   = {in_value_i, cnt_q};
   assign accept = in_valid_i && (state_q == ACCEPT);

   max_comparator u_cmp_max (
      .a_i             (max_q),
      .b_i             (word),
      .out_value_max_o (cmp_max),
      .out_value_min_o ()
   );

   max_comparator u_cmp_min (
      .a_i             (word),
      .b_i             (min_q),
      .out_value_max_o (),
      .out_value_min_o (cmp_min)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      max_d   = max_q;
      min_d   = min_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = ACCEPT;
               cnt_d   = '0;
            end
         end
         ACCEPT: begin
            if (accept) begin
               cnt_d = cnt_q + 1'b1;
               // The first sample seeds both registers; results from the last run are stale.
               if (cnt_q == '0) begin
                  max_d = word;
                  min_d = word;
               end else begin
                  max_d = cmp_max;
                  min_d = cmp_min;
               end
               if (cnt_q == IW'(N - 1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         max_q   <= '0;
         min_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         max_q   <= max_d;
         min_q   <= min_d;
      end
   end

   assign in_ready_o = (state_q == ACCEPT);
   assign busy_o     = (state_q == ACCEPT);
   assign done_o     = (state_q == DONE);
   assign out_max_o  = max_q;
   assign out_min_o  = min_q;

endmodule

// File: tb/tb_max_min_tracker.sv
// Directed and randomized runs of max_min_tracker checked against a first-occurrence max/min model.
module tb_max_min_tracker;
   import tracker_pkg::*;

   localparam int NS = 32;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic                 in_valid;
   logic signed [DW-1:0] in_value;
   logic                 in_ready;
   logic                 busy;
   logic                 done;
   tagged_t              out_max;
   tagged_t              out_min;

   int vec_cnt = 0;
   int err_cnt = 0;
   int smp[NS];

   always #5 clk = ~clk;

   max_min_tracker #(.N(NS)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .in_valid_i (in_valid),
      .in_value_i (in_value),
      .in_ready_o (in_ready),
      .busy_o     (busy),
      .done_o     (done),
      .out_max_o  (out_max),
      .out_min_o  (out_min)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: largest/smallest value, earliest index wins on ties.
   function automatic logic [12:0] ref_word(input bit want_max);
      int bv = smp[0];
      int bi = 0;
      for (int i = 1; i < NS; i++) begin
         if ((want_max && smp[i] > bv) || (!want_max && smp[i] < bv)) begin
            bv = smp[i];
            bi = i;
         end
      end
      return {bv[7:0], bi[4:0]};
   endfunction

   // One run: start, feed all samples (optionally with random valid gaps), check done and results.
   task automatic run(input string tag, input bit stall, input bit hold_start);
      int  acc = 0;
      int  cyc = 0;
      bit  rdy;
      @(negedge clk);
      check({tag, "_idle_ready"}, {31'b0, in_ready}, 32'd0);
      start = 1'b1;
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      check({tag, "_busy"}, {31'b0, busy}, 32'd1);
      while (acc < NS && cyc < 2000) begin
         rdy      = in_ready;
         in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         in_value = 8'(smp[acc]);
         @(negedge clk);
         cyc++;
         if (in_valid && rdy) acc++;
         if (acc < NS) check({tag, "_no_early_done"}, {31'b0, done}, 32'd0);
      end
      in_valid = 1'b0;
      in_value = '0;
      check({tag, "_accepts"}, acc, NS);
      check({tag, "_done"}, {31'b0, done}, 32'd1);
      check({tag, "_ready_in_done"}, {31'b0, in_ready}, 32'd0);
      check({tag, "_max"}, {19'b0, out_max}, {19'b0, ref_word(1'b1)});
      check({tag, "_min"}, {19'b0, out_min}, {19'b0, ref_word(1'b0)});
      @(negedge clk);
      check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
      check({tag, "_idle_after"}, {31'b0, busy}, 32'd0);
      check({tag, "_max_hold"}, {19'b0, out_max}, {19'b0, ref_word(1'b1)});
      start = 1'b0;
      @(negedge clk);
      check({tag, "_stay_idle"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_value = '0;
      repeat (2) @(negedge clk);
      check("rst_max", {19'b0, out_max}, 32'd0);
      check("rst_min", {19'b0, out_min}, 32'd0);
      check("rst_flags", {29'b0, in_ready, busy, done}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < NS; i++) smp[i] = i - 16;
      run("ascend", 1'b0, 1'b0);

      for (int i = 0; i < NS; i++) smp[i] = 7;
      run("ties", 1'b0, 1'b0);

      for (int i = 0; i < NS; i++) smp[i] = 0;
      smp[9]  = 127;
      smp[20] = -128;
      run("extremes", 1'b1, 1'b0);

      // Partial run interrupted by reset after 10 accepts.
      for (int i = 0; i < NS; i++) smp[i] = 50 - i;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_value = 8'(smp[i]);
         @(negedge clk);
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      check("midrst_max", {19'b0, out_max}, 32'd0);
      check("midrst_min", {19'b0, out_min}, 32'd0);
      check("midrst_flags", {29'b0, in_ready, busy, done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      check("midrst_no_done", {31'b0, done}, 32'd0);
      for (int i = 0; i < NS; i++) smp[i] = int'($urandom_range(0, 255)) - 128;
      run("after_rst", 1'b0, 1'b0);

      for (int i = 0; i < NS; i++) smp[i] = int'($urandom_range(0, 40)) - 20;
      run("start_held", 1'b1, 1'b1);

      for (int i = 0; i < NS; i++) smp[i] = 100 - 3 * i;
      run("descend", 1'b0, 1'b0);

      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < NS; i++) smp[i] = int'($urandom_range(0, 255)) - 128;
         run("random", 1'b1, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
